mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 83 ++++++++
 tb/tb_mem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access.
// Ports: clk/reset (sync, active-high); fetch side if_req/if_addr -> if_gnt, if_rvalid/if_rdata/if_raddr;
// data side d_op/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata; memory side mem_en/mem_we/mem_addr/mem_wdata,
// mem_rdata (valid the cycle after a read); conflict_cnt counts cycles with both sides requesting.
module mem_port_arbiter #(
    parameter logic [1:0] MEM_DISABLE   = 2'b00,
    parameter logic [1:0] MEM_READ_SEXT = 2'b01,
    parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
    parameter logic [1:0] MEM_WRITE     = 2'b11,
    parameter int         STARVE_MAX    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic [31:0] if_raddr,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] conflict_cnt
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} ownerT;

    ownerT         readOwner;
    logic [SW-1:0] starveCnt;
    logic [31:0]   fetchAddr, ifRdataQ, ifRaddrQ, dRdataQ;
    logic          dReq, forceFetch;
    logic          unusedAddrBits;

    assign unusedAddrBits = ^{if_addr[31:12], if_addr[1:0], d_addr[31:12], d_addr[1:0], MEM_READ_SEXT, MEM_READ_ZEXT};

    assign dReq       = d_op != MEM_DISABLE;
    assign forceFetch = starveCnt == SW'(STARVE_MAX);
    // Data wins conflicts unless fetch has been denied STARVE_MAX times in a row.
    assign if_gnt     = !reset && if_req && (!dReq || forceFetch);
    assign d_gnt      = !reset && dReq && !(if_req && forceFetch);
    assign mem_en     = if_gnt || d_gnt;
    assign mem_we     = d_gnt && d_op == MEM_WRITE;
    assign mem_addr   = d_gnt ? d_addr[11:2] : if_addr[11:2];
    assign mem_wdata  = d_wdata;

    // Gating with reset drops a response whose read was granted just before reset.
    assign if_rvalid  = !reset && readOwner == OWN_FETCH;
    assign d_rvalid   = !reset && readOwner == OWN_DATA;
    assign if_rdata   = if_rvalid ? mem_rdata : ifRdataQ;
    assign if_raddr   = if_rvalid ? fetchAddr : ifRaddrQ;
    assign d_rdata    = d_rvalid ? mem_rdata : dRdataQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            readOwner    <= OWN_NONE;
            starveCnt    <= '0;
            fetchAddr    <= '0;
            ifRdataQ     <= '0;
            ifRaddrQ     <= '0;
            dRdataQ      <= '0;
            conflict_cnt <= '0;
        end else begin
            starveCnt <= (!if_req || if_gnt) ? '0 : (forceFetch ? starveCnt : starveCnt + 1'b1);
            readOwner <= if_gnt ? OWN_FETCH : (d_gnt && d_op != MEM_WRITE) ? OWN_DATA : OWN_NONE;
            if (if_gnt) fetchAddr <= if_addr;
            if (if_rvalid) begin
                ifRdataQ <= mem_rdata;
                ifRaddrQ <= fetchAddr;
            end
            if (d_rvalid) dRdataQ <= mem_rdata;
            if (if_req && dReq && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;
    localparam logic [1:0] DIS = 2'b00, SEXT = 2'b01, ZEXT = 2'b10, WR = 2'b11;

    logic        clk = 1'b0, reset = 1'b1;
    logic        if_req = 1'b0, d_gnt, if_gnt, if_rvalid, d_rvalid, mem_en, mem_we;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [1:0]  d_op = DIS;
    logic [31:0] if_rdata, if_raddr, d_rdata, mem_wdata, mem_rdata = '0;
    logic [9:0]  mem_addr;
    logic [15:0] conflict_cnt;

    logic [31:0] mem [1024];
    logic [31:0] shw [1024];
    logic [63:0] ifQ [$];
    logic [31:0] dQ [$];
    int          nVec = 0, nErr = 0;
    logic        monOff = 1'b0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_raddr(if_raddr),
        .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 1024; i++) begin
        mem[i] = 32'hC0DE0000 | i;
        shw[i] = 32'hC0DE0000 | i;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (!monOff) begin
        if (if_rvalid) begin
            if (ifQ.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                logic [63:0] e;
                e = ifQ.pop_front();
                chk("if_rdata", if_rdata, e[63:32]);
                chk("if_raddr", if_raddr, e[31:0]);
            end
        end
        if (d_rvalid) begin
            if (dQ.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
            else chk("d_rdata", d_rdata, dQ.pop_front());
        end
    end

    task automatic step(input logic ifr, input logic [31:0] ia, input logic [1:0] op,
                        input logic [31:0] da, input logic [31:0] wd, input logic eIf, input logic eD);
        logic [31:0] a;
        if_req = ifr; if_addr = ia; d_op = op; d_addr = da; d_wdata = wd;
        @(negedge clk);
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, eIf});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, eD});
        chk("mem_en", {31'b0, mem_en}, {31'b0, eIf | eD});
        chk("mem_we", {31'b0, mem_we}, {31'b0, eD && op == WR});
        if (eIf || eD) begin
            a = eD ? da : ia;
            chk("mem_addr", {22'b0, mem_addr}, {22'b0, a[11:2]});
        end
        if (eIf) ifQ.push_back({shw[ia[11:2]], ia});
        if (eD && op == WR) begin
            chk("mem_wdata", mem_wdata, wd);
            shw[da[11:2]] = wd;
        end else if (eD) dQ.push_back(shw[da[11:2]]);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, DIS, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_conflict", {16'b0, conflict_cnt}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        step(1'b1, 32'h40, DIS, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("hold_if_rdata", if_rdata, 32'hC0DE0010);
        chk("hold_if_raddr", if_raddr, 32'h40);
        chk("hold_if_rvalid", {31'b0, if_rvalid}, 32'd0);

        step(1'b0, 32'h0, WR, 32'h84, 32'hDEADBEEF, 1'b0, 1'b1);
        step(1'b0, 32'h0, ZEXT, 32'h84, 32'h0, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 5; i++) step(1'b1, 32'h100, ZEXT, 32'h200, 32'h0, i == 3, i != 3);
        idle();
        chk("conflict_5", {16'b0, conflict_cnt}, 32'd5);

        for (int i = 0; i < 6; i++)
            if (i % 2 == 0) step(1'b0, 32'h0, SEXT, 32'h300 + 4 * i, 32'h0, 1'b0, 1'b1);
            else step(1'b1, 32'h400 + 4 * i, DIS, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h43, DIS, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        if_req = 1'b0; d_op = ZEXT; d_addr = 32'h8;
        @(negedge clk);
        chk("pre_rst_d_gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; if_req = 1'b1;
        @(negedge clk);
        chk("rst_drop_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        chk("rst_if_gnt2", {31'b0, if_gnt}, 32'd0);
        chk("rst_mem_en2", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we2", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; if_req = 1'b0; d_op = DIS;
        @(negedge clk);
        chk("post_rst_valids", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        chk("post_rst_if_rdata", if_rdata, 32'd0);
        chk("post_rst_d_rdata", d_rdata, 32'd0);
        chk("post_rst_if_raddr", if_raddr, 32'd0);
        chk("post_rst_conflict", {16'b0, conflict_cnt}, 32'd0);
        @(posedge clk); #1;

        monOff = 1'b1;
        if_req = 1'b1; d_op = ZEXT; d_addr = 32'h10; if_addr = 32'h20;
        repeat (65535) @(posedge clk);
        #1;
        chk("conflict_65535", {16'b0, conflict_cnt}, 32'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        if_req = 1'b0; d_op = DIS;
        @(negedge clk);
        chk("conflict_sat", {16'b0, conflict_cnt}, 32'hFFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        monOff = 1'b0;
        chk("conflict_nowrap", {16'b0, conflict_cnt}, 32'hFFFF);
        chk("ifQ_drained", ifQ.size(), 32'd0);
        chk("dQ_drained", dQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
